mem_access_unit: RTL
====================

# mem_access_unit

Initiator side of the data-memory interface: accepts one load/store request at a time from the RV32I datapath and drives the RAM port (`we[1:0]`, `addr`, `wData`, `rData`). For stores it encodes width into `we`. For loads it samples the RAM's combinational word read, extracts the byte or half-word lane and sign- or zero-extends it. It flags misaligned or illegal accesses without touching memory. It sits between the execute stage and the data RAM.

## Interface
- `ADDR_W`, 32, address width; `mem_addr` and `req_addr` use this width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned or illegal request, valid with `rsp_valid`.
- `mem_we`  out  2  00 none, 01 byte, 10 half, 11 word.
- `mem_addr`  out  ADDR_W  RAM address.
- `mem_wData`  out  32  RAM write data.
- `mem_rData`  in  32  RAM word read data, combinational from `mem_addr`.

## Operation
- **States.** IDLE, ACCESS, RESP.
- **IDLE.**
  - `req_ready`=1.
  - On `req_valid`: latch write, funct3, addr and wdata, then classify the request.
  - Legal request → ACCESS; error → RESP with the error flag set.
- **Errors.**
  - funct3 ∈ {011, 110, 111}.
  - Store with funct3 100 or 101.
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠00.
- **ACCESS (exactly one cycle).**
  - `mem_addr` = latched addr.
  - Store: `mem_we` = width code, `mem_wData` = latched wdata, unshifted; the RAM places low bits into the lane selected by addr[1:0].
  - Load: `mem_we`=00; capture `mem_rData` into the response register at the closing edge.
  - Next state: RESP.
- **RESP (one cycle).**
  - `rsp_valid`=1, `rsp_err` as classified, `rsp_rdata` as captured.
  - Next state: IDLE.
- **Load extraction.**
  - Byte = `rData[8*addr[1:0] +: 8]`.
  - Half = `rData[16*addr[1] +: 16]`.
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- **Outside ACCESS.** `mem_we`=00 and `mem_wData`=0; `mem_addr` holds the last latched address.
- **Side effects.** Errors never assert `mem_we`.

## Timing
- **Cycle numbering.** Request sampled at edge E0. ACCESS runs E0→E1; `rsp_valid` is high E1→E2; IDLE again after E2.
- **Error path.** E0 → RESP directly; `rsp_valid` is high E0→E1.
- **Throughput.** At most one request per 3 cycles (2 for errors). `req_valid` while `req_ready`=0 is ignored and must be held by the requester.
- **Combinational output.** `req_ready` is decoded from state and asserts in the same cycle IDLE is entered.
- **Reset values.** State IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `mem_we`=00, `mem_addr`=0, `mem_wData`=0, all latches 0.
- **Reset mid-operation.**
  - `mem_we` drops to 00 asynchronously.
  - An in-flight store whose ACCESS edge has not occurred is not written.
  - No `rsp_valid` is issued for the aborted request.
- **Simultaneous events.** `req_valid` during RESP is not accepted; it is accepted in the following IDLE cycle.

## Structure
- Package `mem_pkg`:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - `we` enum: WE_NONE=00, WE_BYTE=01, WE_HALF=10, WE_WORD=11.
  - FSM state enum.
  - Shared with RAM and datapath.
- Sub-module `load_align`: combinational lane select plus extension (inputs rData, addr[1:0], funct3). The FSM and latches live in `mem_access_unit`.

## Test plan
- **SW:** addr 0x8, wdata 0xDEADBEEF → ACCESS cycle shows `mem_we`=11, `mem_addr`=0x8; RESP `rsp_err`=0; a later LW at 0x8 returns 0xDEADBEEF.
- **SB then LB/LBU:** SB addr 0x5, wdata 0x000000F0 → `mem_we`=01. LB at 0x5 returns 0xFFFFFFF0; LBU at 0x5 returns 0x000000F0.
- **SH then LH/LHU:** SH addr 0x6, wdata 0x8001 → `mem_we`=10. LH at 0x6 returns 0xFFFF8001; LHU at 0x6 returns 0x00008001.
- **Errors:**
  - LW at 0x2 → `rsp_valid` one cycle after accept, `rsp_err`=1, `rsp_rdata`=0, `mem_we` never nonzero.
  - SH at 0x3 → same.
  - Store with funct3=100 → `rsp_err`=1.
- **Reset during ACCESS of SW** 0x55AA55AA at 0xC → `mem_we` 00 immediately, no `rsp_valid`; a later LW at 0xC returns the prior contents.
- **Back-to-back:** hold `req_valid` high for two stores → second accepted exactly 3 cycles after the first; `req_ready` low in ACCESS and RESP.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory interface: RV32I width codes,
// RAM write-enable encoding and the access-unit FSM states.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        WE_NONE = 2'b00,
        WE_BYTE = 2'b01,
        WE_HALF = 2'b10,
        WE_WORD = 2'b11
    } we_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_e;

    function automatic we_e width_we(input logic [2:0] funct3);
        we_e we;
        case (funct3)
            F3_B, F3_BU: we = WE_BYTE;
            F3_H, F3_HU: we = WE_HALF;
            F3_W:        we = WE_WORD;
            default:     we = WE_NONE;
        endcase
        return we;
    endfunction

    // Unsigned widths have no store form; halves and words need natural alignment.
    function automatic logic req_illegal(input logic write, input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
        logic bad;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_BU:   bad = write;
            F3_H:    bad = addr_lo[0];
            F3_HU:   bad = write | addr_lo[0];
            F3_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane extraction: picks the byte or half-word addressed within the
// RAM word and sign- or zero-extends it to 32 bits.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane select and extension.
    always_comb begin
        byte_s = rdata_i[{addr_i, 3'b000} +: 8];
        half_s = rdata_i[{addr_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_B:    data_o = {{24{byte_s[7]}}, byte_s};
            F3_BU:   data_o = {24'h000000, byte_s};
            F3_H:    data_o = {{16{half_s[15]}}, half_s};
            F3_HU:   data_o = {16'h0000, half_s};
            F3_W:    data_o = rdata_i;
            default: data_o = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory initiator: one load/store at a time, IDLE -> ACCESS -> RESP,
// with illegal or misaligned requests answered from IDLE without a RAM access.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wData,
    input  logic [31:0]       mem_rData
);

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       load_data_s;
    logic              accept_s;

    load_align u_load_align (
        .rdata_i  (mem_rData),
        .addr_i   (addr_q[1:0]),
        .funct3_i (funct3_q),
        .data_o   (load_data_s)
    );

    // State and request latches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0000_0000;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign accept_s = (state_q == ST_IDLE) && req_valid;

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = req_illegal(req_write, req_funct3, req_addr[1:0]) ? ST_RESP : ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Latch capture on accept; load data captured at the close of ACCESS.
    always_comb begin
        write_d  = write_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        if (accept_s) begin
            write_d  = req_write;
            funct3_d = req_funct3;
            addr_d   = req_addr;
            wdata_d  = req_wdata;
            err_d    = req_illegal(req_write, req_funct3, req_addr[1:0]);
            rdata_d  = 32'h0000_0000;
        end else if ((state_q == ST_ACCESS) && !write_q) begin
            rdata_d  = load_data_s;
        end else begin
            rdata_d  = rdata_q;
        end
    end

    // Outputs decoded from state so the RAM strobe drops with the async reset.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        rsp_err   = (state_q == ST_RESP) ? err_q : 1'b0;
        rsp_rdata = rdata_q;
        mem_addr  = addr_q;
        if ((state_q == ST_ACCESS) && write_q) begin
            mem_we    = width_we(funct3_q);
            mem_wData = wdata_q;
        end else begin
            mem_we    = WE_NONE;
            mem_wData = 32'h0000_0000;
        end
    end

endmodule
